pls_dac_formatter: RTL and testbench

Downstream stage of the pulse generator: accepts the generator's float32 sample stream over AXI-Stream, converts each sample to a fixed-point DAC code with saturation, buffers codes in a FIFO, and releases them to the DAC pins at a programmable sample rate. It decouples the variable-latency, adder-bound generator from the constant-rate DAC. It also reports underrun and saturation status.

---
 rtl/pls_dac_formatter.sv | 232 +++++++++++++++++++++++
 tb/tb_pls_dac_formatter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pls_dac_formatter.sv
// pls_dac_formatter
//   Takes the pulse generator's float32 sample stream and turns each sample
//   into a saturated fixed-point DAC code. Codes are buffered in a FIFO and
//   released to the DAC pins at a programmable, constant rate. This absorbs
//   the generator's variable latency. Underrun and saturation status are
//   also reported.
//
// Ports
//   aclk, areset        clock, synchronous active-high reset
//   s_axis_tdata/tvalid float32 input sample (AXI-Stream slave)
//   s_axis_tready       high while a credit is free (FIFO + pipeline < depth)
//   enable, rate_div    pacer run and output period in aclk cycles (0 acts as 1)
//   offset_binary       1 = offset-binary pin format, 0 = two's complement
//   clr_status          one-cycle clear of underrun and sat_count
//   dac_data            DAC code, registered raw code formatted combinationally
//   dac_strobe          one-cycle pulse when dac_data takes a new code
//   underrun            sticky, a pacer tick found the FIFO empty
//   sat_count           saturating count of clipped or NaN samples
//   fifo_level          number of codes currently held in the FIFO
module pls_dac_formatter #(
  parameter int DATA_SIZE  = 32,
  parameter int DAC_WIDTH  = 14,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [DATA_SIZE-1:0]          s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          enable,
  input  logic [DIV_WIDTH-1:0]          rate_div,
  input  logic                          offset_binary,
  input  logic                          clr_status,
  output logic [DAC_WIDTH-1:0]          dac_data,
  output logic                          dac_strobe,
  output logic                          underrun,
  output logic [15:0]                   sat_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int W  = DAC_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);

  // Biased exponents below MIN_EXP scale to less than one LSB.
  localparam logic [7:0]    MIN_EXP    = 8'(128 - W);
  // Right shift of {1,mantissa} is SHIFT_BASE - biased exponent.
  localparam logic [8:0]    SHIFT_BASE = 9'(151 - W);
  localparam logic [W-1:0]  CODE_MAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  CODE_MIN   = {1'b1, {(W-1){1'b0}}};
  localparam logic [AW:0]   DEPTH_L    = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_CLAMP,
    CLS_NEG_ONE,
    CLS_NAN
  } cls_t;

  logic               accept;
  logic               in_sign;
  logic [7:0]         in_exp;
  logic [22:0]        in_mant;
  cls_t               in_cls;
  logic [4:0]         in_shift;

  logic               s1_valid;
  logic               s1_sign;
  cls_t               s1_cls;
  logic [4:0]         s1_shift;
  logic [22:0]        s1_mant;

  logic [W-1:0]       s2_mag;
  logic [W-1:0]       s2_code;
  logic               s2_sat;
  logic               sat_event;

  logic [W-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic               push;
  logic               pop;
  logic               fifo_empty;

  logic [DIV_WIDTH-1:0] pace_cnt;
  logic [DIV_WIDTH-1:0] div_last;
  logic               tick;

  logic [W-1:0]       raw;

  assign in_sign = s_axis_tdata[31];
  assign in_exp  = s_axis_tdata[30:23];
  assign in_mant = s_axis_tdata[22:0];

  // A credit is held by every stored code and by a sample sitting in S1, so
  // a sample is never accepted without a FIFO slot reserved for it.
  assign s_axis_tready = !areset && ((count + (AW+1)'(s1_valid)) < DEPTH_L);
  assign accept        = s_axis_tvalid && s_axis_tready;

  // S1 classification: Inf/NaN, |x| >= 1 (with exactly -1.0 as the one
  // in-range case), too small or denormal, or a normal value to be shifted.
  always_comb begin
    in_cls   = CLS_NORM;
    in_shift = 5'(SHIFT_BASE - {1'b0, in_exp});
    if (in_exp == 8'hFF) begin
      in_cls = (in_mant != '0) ? CLS_NAN : CLS_CLAMP;
    end else if (in_exp >= 8'd127) begin
      in_cls = (in_sign && in_exp == 8'd127 && in_mant == '0) ? CLS_NEG_ONE : CLS_CLAMP;
    end else if (in_exp == 8'd0 || in_exp < MIN_EXP) begin
      in_cls = CLS_ZERO;
    end
  end

  // S1 register: holds the unpacked, classified sample for one cycle.
  always_ff @(posedge aclk) begin
    if (areset) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_cls   <= CLS_ZERO;
      s1_shift <= '0;
      s1_mant  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_sign  <= in_sign;
        s1_cls   <= in_cls;
        s1_shift <= in_shift;
        s1_mant  <= in_mant;
      end
    end
  end

  // S2: shift, apply the sign, and clamp. The result goes straight into the FIFO.
  always_comb begin
    s2_mag  = W'({1'b1, s1_mant} >> s1_shift);
    s2_code = '0;
    s2_sat  = 1'b0;
    case (s1_cls)
      CLS_NORM:    s2_code = s1_sign ? -s2_mag : s2_mag;
      CLS_CLAMP: begin
        s2_code = s1_sign ? CODE_MIN : CODE_MAX;
        s2_sat  = 1'b1;
      end
      CLS_NEG_ONE: s2_code = CODE_MIN;
      CLS_NAN:     s2_sat  = 1'b1;
      default:     s2_code = '0;
    endcase
  end

  assign sat_event  = s1_valid && s2_sat;
  assign push       = s1_valid;
  assign fifo_empty = (count == '0);
  assign pop        = tick && !fifo_empty;
  assign fifo_level = count;

  // FIFO storage. It has no reset because the pointers define what is valid.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= s2_code;
    end
  end

  // FIFO pointers wrap naturally; the level counter tells full from empty.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // The pacer compares against the live rate_div, so a new period applies at
  // the next compare. A counter already past the new limit ticks at once.
  assign div_last = (rate_div == '0) ? '0 : rate_div - DIV_WIDTH'(1);
  assign tick     = enable && (pace_cnt >= div_last);

  always_ff @(posedge aclk) begin
    if (areset || !enable) begin
      pace_cnt <= '0;
    end else if (tick) begin
      pace_cnt <= '0;
    end else begin
      pace_cnt <= pace_cnt + DIV_WIDTH'(1);
    end
  end

  // Output stage. On a tick the FIFO head goes to the raw register. A tick
  // that finds the FIFO empty sets the sticky underrun flag instead. A set
  // event in the same cycle as clr_status takes priority over the clear.
  always_ff @(posedge aclk) begin
    if (areset) begin
      raw        <= '0;
      dac_strobe <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      dac_strobe <= pop;
      if (pop) begin
        raw <= mem[rd_ptr];
      end
      underrun <= (underrun && !clr_status) || (tick && fifo_empty);
    end
  end

  // The saturation counter sticks at all-ones. A clear that coincides with
  // a new event leaves a count of one.
  always_ff @(posedge aclk) begin
    if (areset) begin
      sat_count <= '0;
    end else if (clr_status) begin
      sat_count <= sat_event ? 16'd1 : 16'd0;
    end else if (sat_event && sat_count != 16'hFFFF) begin
      sat_count <= sat_count + 16'd1;
    end
  end

  assign dac_data = offset_binary ? {~raw[W-1], raw[W-2:0]} : raw;

endmodule

// File: tb/tb_pls_dac_formatter.sv
module tb_pls_dac_formatter;

  localparam int W = 14;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        enable;
  logic [15:0] rate_div;
  logic        offset_binary;
  logic        clr_status;
  logic [W-1:0] dac_data;
  logic        dac_strobe;
  logic        underrun;
  logic [15:0] sat_count;
  logic [4:0]  fifo_level;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int exp_sat = 0;

  typedef struct {
    logic [31:0]  data;
    logic         ob;
    logic [W-1:0] pin;
    logic [15:0]  sat;
  } vec_t;

  vec_t vecs[14];

  pls_dac_formatter #(
    .DATA_SIZE(32), .DAC_WIDTH(W), .FIFO_DEPTH(16), .DIV_WIDTH(16)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .enable(enable), .rate_div(rate_div), .offset_binary(offset_binary), .clr_status(clr_status),
    .dac_data(dac_data), .dac_strobe(dac_strobe), .underrun(underrun),
    .sat_count(sat_count), .fifo_level(fifo_level)
  );

  // Free-running 100 MHz-style clock.
  always #5 aclk = ~aclk;

  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) begin
      for (int i = 0; i < e; i++) r = r * 2.0;
    end else begin
      for (int i = 0; i < -e; i++) r = r / 2.0;
    end
    return r;
  endfunction

  // Reference converter built on real arithmetic: {sat, code}.
  function automatic logic [W:0] modelConvert(input logic [31:0] f);
    int ex;
    int iv;
    real mag;
    real scaled;
    logic [W-1:0] code;
    logic sat;
    ex   = int'(f[30:23]);
    code = '0;
    sat  = 1'b0;
    if (ex == 255) begin
      sat = 1'b1;
      if (f[22:0] == 23'd0) code = f[31] ? 14'h2000 : 14'h1FFF;
    end else begin
      if (ex == 0) mag = real'(f[22:0]) * pow2(-149);
      else         mag = (1.0 + real'(f[22:0]) * pow2(-23)) * pow2(ex - 127);
      if (mag >= 1.0 && !(f[31] && mag == 1.0)) begin
        sat  = 1'b1;
        code = f[31] ? 14'h2000 : 14'h1FFF;
      end else begin
        scaled = mag * 8192.0;
        if (f[31]) scaled = -scaled;
        iv   = $rtoi(scaled);
        code = iv[W-1:0];
      end
    end
    return {sat, code};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExpected(input logic [31:0] d);
    logic [W:0] m;
    m = modelConvert(d);
    exp_q.push_back(m[W-1:0]);
    if (m[W]) exp_sat++;
  endtask

  // Entered and left at posedge+1; holds tvalid until the sample is taken.
  task automatic applyStimulus(input logic [31:0] d);
    int n;
    n = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 50) begin
      @(posedge aclk); #1;
      n++;
    end
    checkOutput("tready_for_sample", s_axis_tready, 1);
    if (s_axis_tready) begin
      pushExpected(d);
      @(posedge aclk); #1;
    end
    s_axis_tvalid = 1'b0;
  endtask

  // Leaves the caller at the negedge where dac_strobe was seen.
  task automatic waitStrobe(input string name, input int budget);
    int n;
    n = 0;
    @(negedge aclk);
    while (!dac_strobe && n < budget) begin
      @(negedge aclk);
      n++;
    end
    checkOutput(name, dac_strobe, 1);
  endtask

  task automatic waitLevel(input int target, input int budget);
    int n;
    n = 0;
    while (fifo_level != 5'(target) && n < budget) begin
      @(posedge aclk); #1;
      n++;
    end
    checkOutput("fifo_level_reached", fifo_level, target);
  endtask

  task automatic applyReset();
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    clr_status    = 1'b0;
    @(posedge aclk); #1;
    exp_q.delete();
    exp_sat = 0;
    checkOutput("tready_during_reset", s_axis_tready, 0);
    checkOutput("level_after_reset", fifo_level, 0);
    checkOutput("strobe_after_reset", dac_strobe, 0);
    checkOutput("underrun_after_reset", underrun, 0);
    checkOutput("sat_after_reset", sat_count, 0);
    checkOutput("data_after_reset", dac_data, offset_binary ? 14'h2000 : 14'h0000);
    areset = 1'b0;
    #1;
    checkOutput("tready_after_reset", s_axis_tready, 1);
    @(posedge aclk); #1;
  endtask

  // Scoreboard: every strobe must consume the oldest expected code.
  always @(negedge aclk) begin
    if (!areset && dac_strobe) begin
      logic [W-1:0] c;
      checkOutput("strobe_has_expected", (exp_q.size() != 0) ? 1 : 0, 1);
      if (exp_q.size() != 0) begin
        c = exp_q.pop_front();
        checkOutput("scoreboard_code", dac_data, offset_binary ? {~c[W-1], c[W-2:0]} : c);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [17:0] strobe_mask;
    logic [17:0] under_mask;
    logic [5:0]  fast_mask;
    int accepted;
    int idx;
    int n;
    logic [31:0] d;

    vecs[0]  = '{32'h3F000000, 1'b0, 14'h1000, 16'd0};
    vecs[1]  = '{32'hBF000000, 1'b0, 14'h3000, 16'd0};
    vecs[2]  = '{32'h3F800000, 1'b0, 14'h1FFF, 16'd1};
    vecs[3]  = '{32'hBF800000, 1'b0, 14'h2000, 16'd1};
    vecs[4]  = '{32'h7FC00000, 1'b0, 14'h0000, 16'd2};
    vecs[5]  = '{32'h35800000, 1'b0, 14'h0000, 16'd2};
    vecs[6]  = '{32'h3F000000, 1'b1, 14'h3000, 16'd2};
    vecs[7]  = '{32'hFF800000, 1'b0, 14'h2000, 16'd3};
    vecs[8]  = '{32'h3E800001, 1'b0, 14'h0800, 16'd3};
    vecs[9]  = '{32'hBE800000, 1'b0, 14'h3800, 16'd3};
    vecs[10] = '{32'h80000000, 1'b0, 14'h0000, 16'd3};
    vecs[11] = '{32'hBF7FFFFF, 1'b1, 14'h0001, 16'd3};
    vecs[12] = '{32'h39000000, 1'b0, 14'h0001, 16'd3};
    vecs[13] = '{32'h38FFFFFF, 1'b0, 14'h0000, 16'd3};

    areset        = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    enable        = 1'b0;
    rate_div      = 16'd1;
    offset_binary = 1'b0;
    clr_status    = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    applyReset();
    offset_binary = 1'b1;
    #1;
    checkOutput("reset_offset_binary", dac_data, 14'h2000);
    offset_binary = 1'b0;
    @(posedge aclk); #1;

    $display("[TB] conversion table");
    enable   = 1'b1;
    rate_div = 16'd1;
    for (int i = 0; i < 14; i++) begin
      offset_binary = vecs[i].ob;
      applyStimulus(vecs[i].data);
      waitStrobe($sformatf("strobe_v%0d", i), 20);
      checkOutput($sformatf("pin_v%0d", i), dac_data, vecs[i].pin);
      checkOutput($sformatf("sat_v%0d", i), sat_count, vecs[i].sat);
      @(posedge aclk); #1;
    end
    offset_binary = 1'b0;

    $display("[TB] random conversions");
    for (int i = 0; i < 12; i++) begin
      d = {1'($urandom_range(0, 1)), 8'($urandom_range(105, 130)), 23'($urandom)};
      applyStimulus(d);
      waitStrobe("strobe_random", 20);
      @(posedge aclk); #1;
    end
    checkOutput("sat_random", sat_count, exp_sat);

    $display("[TB] pacing");
    enable = 1'b0;
    applyReset();
    rate_div = 16'd4;
    applyStimulus(32'h3E800000);
    applyStimulus(32'hBE000000);
    applyStimulus(32'h3D800000);
    waitLevel(3, 10);
    enable      = 1'b1;
    strobe_mask = '0;
    under_mask  = '0;
    for (int c = 0; c < 18; c++) begin
      @(negedge aclk);
      strobe_mask[c] = dac_strobe;
      under_mask[c]  = underrun;
    end
    @(posedge aclk); #1;
    checkOutput("pacing_strobes", strobe_mask, 18'h01110);
    checkOutput("pacing_underrun", under_mask, 18'h30000);
    checkOutput("pacing_hold_data", dac_data, 14'h0200);
    enable = 1'b0;

    $display("[TB] backpressure");
    accepted      = 0;
    idx           = 0;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d = {idx[0], 8'(118 + (idx % 8)), 23'(idx * 173479)};
      s_axis_tdata = d;
      if (s_axis_tready) begin
        pushExpected(d);
        accepted++;
        idx++;
      end
      @(posedge aclk); #1;
    end
    s_axis_tvalid = 1'b0;
    checkOutput("bp_accepted", accepted, 16);
    checkOutput("bp_tready_full", s_axis_tready, 0);
    checkOutput("bp_level_full", fifo_level, 16);
    rate_div = 16'd1;
    enable   = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge aclk); #1;
      n++;
    end
    checkOutput("bp_drained", exp_q.size(), 0);
    checkOutput("bp_tready_back", s_axis_tready, 1);
    checkOutput("bp_level_empty", fifo_level, 0);
    enable = 1'b0;

    $display("[TB] rate_div zero");
    for (int i = 0; i < 4; i++) applyStimulus({1'b0, 8'(122 + i), 23'(i * 99991)});
    waitLevel(4, 10);
    rate_div  = 16'd0;
    enable    = 1'b1;
    fast_mask = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      fast_mask[c] = dac_strobe;
    end
    @(posedge aclk); #1;
    checkOutput("div0_strobes", fast_mask, 6'b011110);
    enable = 1'b0;

    $display("[TB] saturation clear with coincident event");
    applyStimulus(32'h40000000);
    @(posedge aclk); #1;
    checkOutput("sat_before_clear", sat_count, exp_sat);
    applyStimulus(32'h3F800000);
    clr_status = 1'b1;
    @(posedge aclk); #1;
    clr_status = 1'b0;
    exp_sat    = 1;
    checkOutput("sat_clear_coincident", sat_count, 1);
    enable   = 1'b1;
    rate_div = 16'd1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge aclk); #1;
      n++;
    end
    checkOutput("sat_drain", exp_q.size(), 0);

    $display("[TB] mid-stream reset");
    applyReset();
    enable   = 1'b1;
    rate_div = 16'd1;
    repeat (2) begin
      @(posedge aclk); #1;
    end
    enable = 1'b0;
    applyStimulus(32'h3F800000);
    applyStimulus(32'h40000000);
    applyStimulus(32'hFF800000);
    applyStimulus(32'h3F000000);
    applyStimulus(32'hBF000000);
    applyStimulus(32'h3E800000);
    applyStimulus(32'hBE800000);
    applyStimulus(32'h3D800000);
    waitLevel(8, 10);
    checkOutput("pre_reset_underrun", underrun, 1);
    checkOutput("pre_reset_sat", sat_count, 3);
    applyReset();

    $display("[TB] clr_status vs underrun");
    rate_div = 16'd4;
    enable   = 1'b1;
    repeat (3) begin
      @(posedge aclk); #1;
    end
    checkOutput("underrun_before_tick", underrun, 0);
    clr_status = 1'b1;
    @(posedge aclk); #1;
    checkOutput("underrun_set_wins", underrun, 1);
    @(posedge aclk); #1;
    clr_status = 1'b0;
    checkOutput("underrun_cleared", underrun, 0);
    enable = 1'b0;
    @(posedge aclk); #1;

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
